// File: rtl/ldm_stm_seq.sv
// Block-transfer sequencer for load/store-multiple: walks a register list,
// issues one word access per selected register, then optionally writes back the base.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        pre,
  input  logic        up,
  input  logic        wb,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_val,
  input  logic [14:0] reg_list,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  rf_a0,
  input  logic [31:0] rf_q0,
  output logic [3:0]  rf_write_reg,
  output logic [31:0] rf_data_in,
  output logic        rf_we
);

  // state | meaning
  // IDLE  | waiting for start; request inputs latched on start
  // XFER  | one memory access per remaining list bit, lowest index first
  // WB    | one-cycle base register write-back
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t      state;
  logic [14:0] rem;
  logic        lat_load;
  logic        lat_wb;
  logic        lat_wb_en;
  logic [3:0]  lat_base_reg;
  logic [31:0] lat_wb_val;

  logic [4:0]  n_cnt;
  logic [31:0] n_bytes;
  logic [31:0] start_addr;
  logic [3:0]  cur_idx;
  logic [14:0] rem_next;
  logic [15:0] list_ext;
  logic        wb_hit;
  logic        ack_ok;

  always_comb begin
    n_cnt = '0;
    for (int i = 0; i < 15; i++) n_cnt = n_cnt + {4'd0, reg_list[i]};
  end

  assign n_bytes  = {25'd0, n_cnt, 2'b00};
  assign list_ext = {1'b0, reg_list};
  // a loaded base register keeps its loaded value, and r15 is never written back
  assign wb_hit   = (base_reg != 4'd15) && !(is_load && list_ext[base_reg]);

  always_comb begin
    case ({up, pre})
      2'b10:   start_addr = base_val;
      2'b11:   start_addr = base_val + 32'd4;
      2'b00:   start_addr = base_val - n_bytes + 32'd4;
      default: start_addr = base_val - n_bytes;
    endcase
  end

  always_comb begin
    cur_idx = '0;
    for (int i = 14; i >= 0; i--) if (rem[i]) cur_idx = i[3:0];
  end

  assign rem_next  = rem & ~(15'd1 << cur_idx);
  assign ack_ok    = (state == XFER) && mem_req && mem_ack;
  assign rf_a0     = (state == XFER) ? cur_idx : 4'd0;
  assign mem_wdata = rf_q0;

  always_comb begin
    rf_we        = 1'b0;
    rf_write_reg = '0;
    rf_data_in   = '0;
    if (ack_ok && lat_load) begin
      rf_we        = 1'b1;
      rf_write_reg = cur_idx;
      rf_data_in   = mem_rdata;
    end else if (state == WB && lat_wb_en) begin
      rf_we        = 1'b1;
      rf_write_reg = lat_base_reg;
      rf_data_in   = lat_wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      rem          <= '0;
      lat_load     <= 1'b0;
      lat_wb       <= 1'b0;
      lat_wb_en    <= 1'b0;
      lat_base_reg <= '0;
      lat_wb_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lat_load     <= is_load;
            lat_wb       <= wb;
            lat_wb_en    <= wb && wb_hit;
            lat_base_reg <= base_reg;
            lat_wb_val   <= up ? base_val + n_bytes : base_val - n_bytes;
            rem          <= reg_list;
            mem_addr     <= start_addr;
            if (n_cnt == 5'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= XFER;
              busy    <= 1'b1;
              mem_req <= 1'b1;
              mem_we  <= ~is_load;
            end
          end
        end
        XFER: begin
          if (mem_req && mem_ack) begin
            mem_req  <= 1'b0;
            rem      <= rem_next;
            mem_addr <= mem_addr + 32'd4;
            if (rem_next == 15'd0) begin
              mem_we <= 1'b0;
              if (lat_wb) begin
                state <= WB;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end else if (!mem_req) begin
            mem_req <= 1'b1;
          end
        end
        WB: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Randomized bench for ldm_stm_seq: a transaction-level model predicts the
// access stream and register writes, and a memory responder inserts wait states.
module tb_ldm_stm_seq;

  logic        clk, rst, start, is_load, pre, up, wb;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [14:0] reg_list;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [3:0]  rf_a0, rf_write_reg;
  logic [31:0] rf_q0, rf_data_in;
  logic        rf_we;

  ldm_stm_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .pre(pre), .up(up),
    .wb(wb), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_a0(rf_a0), .rf_q0(rf_q0), .rf_write_reg(rf_write_reg),
    .rf_data_in(rf_data_in), .rf_we(rf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // register file model, written only by the DUT's write port
  logic [31:0] regs [16];
  assign rf_q0 = regs[rf_a0];
  always @(posedge clk) if (rf_we) regs[rf_write_reg] <= rf_data_in;

  logic [31:0] exp_addr [$];
  logic        exp_we   [$];
  logic [31:0] exp_data [$];
  logic [3:0]  exp_rreg [$];
  logic [31:0] exp_rdata[$];

  bit resp_en = 1'b1;
  bit mon_en  = 1'b1;
  int wait_min = 0, wait_max = 0;
  bit req_seen = 1'b0;
  int wait_left = 0;
  bit holding = 1'b0;
  logic [31:0] hold_addr;
  logic hold_we;
  int gap_phase = 0;
  int done_cnt = 0;

  task automatic monitor_cycle();
    logic [31:0] a, d;
    logic w;
    logic [3:0] r;
    if (gap_phase == 1) begin
      chk("req_gap", mem_req, 1'b0);
      gap_phase = (exp_addr.size() > 0) ? 2 : 0;
    end else if (gap_phase == 2) begin
      chk("req_lat", mem_req, 1'b1);
      gap_phase = 0;
    end
    if (mem_req) begin
      if (!holding) begin
        holding = 1'b1; hold_addr = mem_addr; hold_we = mem_we;
      end else begin
        chk("addr_hold", mem_addr, hold_addr);
        chk("we_hold", mem_we, hold_we);
      end
      if (mem_ack) begin
        holding = 1'b0;
        gap_phase = 1;
        if (exp_addr.size() == 0) chk("acc_extra", 1, 0);
        else begin
          a = exp_addr.pop_front(); w = exp_we.pop_front(); d = exp_data.pop_front();
          chk("acc_addr", mem_addr, a);
          chk("acc_we", mem_we, w);
          if (w) chk("acc_wdata", mem_wdata, d);
        end
      end
    end
    if (rf_we) begin
      if (exp_rreg.size() == 0) chk("rf_we_extra", 1, 0);
      else begin
        r = exp_rreg.pop_front(); d = exp_rdata.pop_front();
        chk("rf_reg", rf_write_reg, r);
        chk("rf_data", rf_data_in, d);
      end
    end
    if (done) done_cnt++;
  endtask

  // memory responder: random wait states, stray acks while no request is open
  always begin
    @(negedge clk);
    if (resp_en) begin
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          wait_left = $urandom_range(wait_max, wait_min);
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); req_seen = 1'b0;
        end else begin
          mem_ack = 1'b0; wait_left--;
        end
      end else begin
        mem_ack = ($urandom_range(3, 0) == 0);
        mem_rdata = $urandom;
      end
    end
    #1;
    if (mon_en) monitor_cycle();
  end

  task automatic run_txn(input logic ld, input logic pr, input logic u, input logic w,
                         input logic [3:0] br, input logic [31:0] bv,
                         input logic [14:0] lst, input bit poke);
    int n, k, cycles;
    logic [31:0] lo, a, nb;
    n = 0;
    for (int i = 0; i < 15; i++) if (lst[i]) n++;
    nb = 32'(n) * 32'd4;
    if (u) lo = pr ? bv + 32'd4 : bv;
    else   lo = pr ? bv - nb : bv - nb + 32'd4;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (lst[i]) begin
        a = lo + 32'(k) * 32'd4;
        exp_addr.push_back(a);
        exp_we.push_back(!ld);
        exp_data.push_back(ld ? mem_word(a) : regs[i]);
        if (ld) begin
          exp_rreg.push_back(4'(i));
          exp_rdata.push_back(mem_word(a));
        end
        k++;
      end
    end
    if (w && n > 0 && br < 4'd15 && !(ld && lst[br])) begin
      exp_rreg.push_back(br);
      exp_rdata.push_back(u ? bv + nb : bv - nb);
    end
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; is_load = ld; pre = pr; up = u; wb = w;
    base_reg = br; base_val = bv; reg_list = lst;
    @(negedge clk);
    start = 1'b0;
    is_load = 1'($urandom); pre = 1'($urandom); up = 1'($urandom); wb = 1'($urandom);
    base_reg = 4'($urandom); base_val = $urandom; reg_list = 15'($urandom);
    #2;
    if (n == 0) begin
      chk("empty_done", done, 1'b1);
      chk("empty_busy", busy, 1'b0);
    end else begin
      chk("busy_rise", busy, 1'b1);
    end
    if (poke && n >= 2) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    cycles = 0;
    while (done_cnt == 0 && cycles < 300) begin
      @(negedge clk); #2; cycles++;
    end
    chk("done_seen", 32'(done_cnt != 0), 1);
    @(negedge clk); #2;
    chk("done_once", done_cnt, 1);
    chk("idle_busy", busy, 1'b0);
    chk("acc_q_empty", exp_addr.size(), 0);
    chk("rf_q_empty", exp_rreg.size(), 0);
    exp_addr.delete(); exp_we.delete(); exp_data.delete();
    exp_rreg.delete(); exp_rdata.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] lst;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    rst = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wb = 1'b0;
    base_reg = '0; base_val = '0; reg_list = '0; mem_ack = 1'b0; mem_rdata = '0;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_a0", rf_a0, 0);
    chk("rst_rf_wreg", rf_write_reg, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    wait_min = 1; wait_max = 1;
    run_txn(1, 0, 1, 1, 4'd4, 32'h100, 15'h0005, 0);
    run_txn(0, 1, 0, 1, 4'd3, 32'h200, 15'h7000, 0);
    run_txn(1, 0, 1, 1, 4'd5, 32'h300, 15'h0000, 0);
    run_txn(1, 0, 1, 1, 4'd1, 32'h400, 15'h0002, 0);
    wait_min = 3; wait_max = 3;
    run_txn(1, 1, 1, 1, 4'd2, 32'h500, 15'h0F0F, 0);
    run_txn(0, 0, 0, 1, 4'd15, 32'h600, 15'h0111, 0);
    wait_min = 0; wait_max = 0;
    run_txn(0, 1, 1, 0, 4'd0, 32'h0000_0000, 15'h7FFF, 1);
    run_txn(1, 1, 0, 1, 4'd7, 32'h0000_0008, 15'h4081, 1);

    wait_min = 0; wait_max = 3;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(5, 0))
        0: lst = 15'h0000;
        1: lst = 15'h7FFF;
        2: lst = 15'(1 << $urandom_range(14, 0));
        default: lst = 15'($urandom);
      endcase
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), $urandom, lst, 1'($urandom));
    end

    // reset during the second of four loads
    mon_en = 1'b0; resp_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; pre = 1'b0; up = 1'b1; wb = 1'b1;
    base_reg = 4'd2; base_val = 32'h300; reg_list = 15'h00F0;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    #2;
    chk("abort_t1_we", rf_we, 1);
    chk("abort_t1_reg", rf_write_reg, 4'd4);
    @(negedge clk);
    mem_ack = 1'b0;
    #2;
    chk("abort_gap", mem_req, 0);
    @(negedge clk);
    #2;
    chk("abort_t2_req", mem_req, 1);
    chk("abort_t2_addr", mem_addr, 32'h304);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_0002;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_req", mem_req, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_late_ack", rf_we, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #2;
    chk("abort_idle", busy, 0);
    chk("abort_rf_we", rf_we, 0);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; reg_list = 15'h0001;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #2;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_req", mem_req, 0);
    chk("rst_start_done", done, 0);
    @(negedge clk);
    #2;
    chk("rst_start_idle", busy | done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
